instruction_cache: RTL
======================

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low; ports are named clk and reset_n.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port: read_m1  input  1  datapath fetch request.
REQ-005 Port: address1  input  16  fetch word address.
REQ-006 Port: data1  output  16  fetched instruction; valid only while i_ready=1.
REQ-007 Port: i_ready  output  1  hit this cycle, combinational; datapath stalls PC/IFID while read_m1=1 and i_ready=0.
REQ-008 Port: flush  input  1  invalidate all lines (one-cycle pulse).
REQ-009 Port: mem_req  output  1  line-fill request to memory, held high until acknowledged.
REQ-010 Port: mem_addr  output  16  line base address, address1 latched with bits [1:0]=00.
REQ-011 Port: mem_ack  input  1  one-cycle pulse; mem_line is valid in the same cycle.
REQ-012 Port: mem_line  input  64  four words; word k is mem_line[16k+15:16k].
REQ-013 Port: hit_count, miss_count  output  16 each  statistics; present only per REQ-031.

Function
REQ-014 Organisation SHALL be direct-mapped, 4 lines x 4 words: offset=addr[1:0], index=addr[3:2], tag=addr[15:4] (12 bit), one valid bit per line.
REQ-015 Hit SHALL be state==LOOKUP, read_m1=1, valid[index]=1 and tag match; on a hit, i_ready=1 and data1=word[offset] in the same cycle (zero-cycle hit latency).
REQ-016 When the access is not a hit, i_ready SHALL be 0 and data1 SHALL be 16'h0000.
REQ-017 States SHALL be LOOKUP, MISS_WAIT and FILL, and no others.
REQ-018 LOOKUP -> MISS_WAIT SHALL occur when read_m1=1 and there is a miss; address1 is latched into miss_addr on that edge, and mem_req=1 from the next cycle.
REQ-019 In MISS_WAIT, mem_req=1 and mem_addr={miss_addr[15:2],2'b00}, held stable until mem_ack.
REQ-020 On MISS_WAIT with mem_ack=1, the edge SHALL write mem_line, the tag, and valid=1 into line miss_addr[3:2], then go to FILL; mem_req SHALL be 0 in FILL.
REQ-021 FILL SHALL last one cycle (i_ready=0) and then return to LOOKUP, where the pending request re-looks-up and hits; miss penalty is therefore memory latency + 2 cycles.
REQ-022 If address1 changes during MISS_WAIT or FILL, the fill SHALL complete for miss_addr; the new address is looked up in LOOKUP.
REQ-023 mem_ack SHALL be ignored in LOOKUP and FILL.
REQ-024 read_m1=0 in LOOKUP SHALL start no miss; i_ready=0.
REQ-025 flush in LOOKUP SHALL clear all valid bits on that edge; that cycle SHALL report no hit.
REQ-026 flush in MISS_WAIT or FILL SHALL set flush_pending; all valid bits SHALL be cleared on the edge entering LOOKUP, so the just-filled line is also invalidated.
REQ-027 A fill to a valid line SHALL overwrite it with no writeback; the cache is read-only.

Reset
REQ-028 When reset_n=0 at the clock edge: state=LOOKUP, all valid=0, flush_pending=0, miss_addr=0, and counters=0; outputs mem_req=0, mem_addr=0, i_ready=0, data1=0.
REQ-029 Reset mid-miss SHALL abandon the fill, with mem_req low in the first cycle after the reset edge; a mem_ack arriving later SHALL be ignored.
REQ-030 Tag and data arrays need no reset; only the valid bits gate hits.

Configuration
REQ-031 Macro ICACHE_STATS_EN: when defined, hit_count increments on each hit cycle and miss_count on each LOOKUP->MISS_WAIT transition, both saturating at 16'hFFFF. Neither counter is cleared by flush.
REQ-032 When ICACHE_STATS_EN is undefined, the hit_count and miss_count ports and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Cold miss: reset, read_m1=1, address1=16'h0005, mem_ack 3 cycles after mem_req with mem_line=64'h4444_3333_2222_1111 -> mem_addr=16'h0004; i_ready=1 with data1=16'h2222 two cycles after mem_ack.
REQ-034 Hit run: after REQ-033, addresses 0004..0007 on consecutive cycles -> i_ready=1 every cycle, data 1111,2222,3333,4444, mem_req stays 0.
REQ-035 Conflict: fill 16'h0010, then access 16'h0050 (same index, tag differs) -> miss and refill; a following access to 16'h0010 misses again.
REQ-036 Flush: after a fill, pulse flush in LOOKUP -> next access to the same address misses; a flush pulsed during MISS_WAIT -> the line just filled also misses after FILL.
REQ-037 Reset mid-miss: reset_n=0 while in MISS_WAIT -> mem_req=0 in the next cycle; a later mem_ack causes no fill, and the access misses again.
REQ-038 With ICACHE_STATS_EN defined: REQ-033 then REQ-034 -> miss_count=1 and hit_count=5 (the re-lookup hit plus 4).

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped 4-line x 4-word read-only instruction cache with a zero-cycle hit path.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module instruction_cache (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read_m1,
    input  logic [15:0] address1,
    output logic [15:0] data1,
    output logic        i_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_line
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic [1:0] {
        LOOKUP,
        MISS_WAIT,
        FILL
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  valid;
    logic [11:0] tag_ram  [4];
    logic [63:0] line_ram [4];
    logic        flush_pending;
    logic [15:2] miss_addr;

    logic [1:0]  index;
    logic [1:0]  offset;
    logic [11:0] tag;
    logic [63:0] cur_line;
    logic        hit;
    logic        miss_start;
    logic        fill_we;
    logic        clear_valid;

    assign offset   = address1[1:0];
    assign index    = address1[3:2];
    assign tag      = address1[15:4];
    assign cur_line = line_ram[index];

    always_comb begin
        state_next  = state;
        hit         = 1'b0;
        miss_start  = 1'b0;
        fill_we     = 1'b0;
        clear_valid = 1'b0;
        data1       = '0;
        case (state)
            LOOKUP: begin
                // A flush cycle never reports a hit, even on a matching line.
                if (read_m1 && !flush && valid[index] && (tag_ram[index] == tag)) begin
                    hit = 1'b1;
                end else if (read_m1) begin
                    miss_start = 1'b1;
                    state_next = MISS_WAIT;
                end
                clear_valid = flush;
            end
            MISS_WAIT: begin
                if (mem_ack) begin
                    fill_we    = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                state_next  = LOOKUP;
                clear_valid = flush_pending | flush;
            end
            default: state_next = LOOKUP;
        endcase
        if (hit) begin
            data1 = cur_line[{offset, 4'b0000} +: 16];
        end
    end

    assign i_ready  = hit;
    assign mem_req  = (state == MISS_WAIT);
    assign mem_addr = {miss_addr, 2'b00};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= LOOKUP;
            valid         <= '0;
            flush_pending <= 1'b0;
            miss_addr     <= '0;
        end else begin
            state <= state_next;
            if (miss_start) begin
                miss_addr <= address1[15:2];
            end
            // A flush seen mid-miss is deferred so it also kills the line being filled.
            if (state == FILL) begin
                flush_pending <= 1'b0;
            end else if ((state == MISS_WAIT) && flush) begin
                flush_pending <= 1'b1;
            end
            if (clear_valid) begin
                valid <= '0;
            end else if (fill_we) begin
                valid[miss_addr[3:2]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && fill_we) begin
            line_ram[miss_addr[3:2]] <= mem_line;
            tag_ram[miss_addr[3:2]]  <= miss_addr[15:4];
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_start && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule
